// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller:
// FSM state encoding, the NOP payload loaded on a flush and the default
// register-specifier width.
package pipe_ctrl_pkg;

   localparam int          REG_W_DEF = 3;
   localparam logic [15:0] NOP_INSTR = 16'h0800;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      MSTALL = 2'd1,
      HALT   = 2'd2
   } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Single register-dependency comparator: flags a match when the consumer
// actually reads its source, the producer actually writes, and the
// specifiers are equal.
module hazard_cmp #(
   parameter int REG_W = 3
) (
   input  logic [REG_W-1:0] src,
   input  logic             src_used,
   input  logic [REG_W-1:0] dst,
   input  logic             dst_written,
   output logic             match
);

   assign match = src_used & dst_written & (src == dst);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core. Generates PC / FD /
// DX / XM write-enables and flushes from data hazards, taken branches,
// memory busy stalls and HALT retirement, and counts stalled cycles.
// Build option: PIPE_FORWARD_EN -- when defined, only load-use stalls
// (forwarding paths cover the rest); otherwise any RAW against EX or MEM
// stalls until the producer leaves MEM.
import pipe_ctrl_pkg::*;

module pipe_hazard_ctrl #(
   parameter int REG_W = REG_W_DEF,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fd_valid,
   input  logic [REG_W-1:0] fd_rs,
   input  logic [REG_W-1:0] fd_rt,
   input  logic             fd_uses_rs,
   input  logic             fd_uses_rt,
   input  logic             fd_halt,
   input  logic [REG_W-1:0] dx_rd,
   input  logic             dx_regwrite,
   input  logic             dx_memread,
   input  logic [REG_W-1:0] xm_rd,
   input  logic             xm_regwrite,
   input  logic             br_taken,
   input  logic             imem_stall,
   input  logic             dmem_stall,
   output logic             pc_we,
   output logic             fd_we,
   output logic             fd_flush,
   output logic             dx_we,
   output logic             dx_flush,
   output logic             xm_we,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt
);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] stall_cnt_reg;

   // Comparator operands: index bit 0 picks rs/rt, bit 1 picks dx/xm.
   logic [1:0][REG_W-1:0] src_vec;
   logic [1:0]            src_use;
   logic [1:0][REG_W-1:0] dst_vec;
   logic [1:0]            dst_wr;
   logic [3:0]            match;
   logic                  raw_dx, raw_xm, data_hazard;

   assign src_vec = {fd_rt, fd_rs};
   assign src_use = {fd_uses_rt, fd_uses_rs};
   assign dst_vec = {xm_rd, dx_rd};
   assign dst_wr  = {xm_regwrite, dx_regwrite};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_cmp
         hazard_cmp #(.REG_W(REG_W)) u_cmp (
            .src         (src_vec[gi % 2]),
            .src_used    (src_use[gi % 2]),
            .dst         (dst_vec[gi / 2]),
            .dst_written (dst_wr[gi / 2]),
            .match       (match[gi])
         );
      end
   endgenerate

   // MW never hazards: the register file writes through.
   assign raw_dx = fd_valid & (match[0] | match[1]);
   assign raw_xm = fd_valid & (match[2] | match[3]);

`ifdef PIPE_FORWARD_EN
   logic unused_raw_xm;
   assign unused_raw_xm = raw_xm;
   assign data_hazard   = raw_dx & dx_memread;
`else
   logic unused_memread;
   assign unused_memread = dx_memread;
   assign data_hazard    = raw_dx | raw_xm;
`endif

   // State register and saturating stall counter, both cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= RUN;
         stall_cnt_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (!pc_we && state_reg != HALT && stall_cnt_reg != {CNT_W{1'b1}})
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
   end

   // Priority-ordered control decode; first matching condition wins.
   always_comb begin
      pc_we      = 1'b1;
      fd_we      = 1'b1;
      fd_flush   = 1'b0;
      dx_we      = 1'b1;
      dx_flush   = 1'b0;
      xm_we      = 1'b1;
      state_next = (state_reg == HALT) ? HALT : RUN;

      if (dmem_stall) begin
         // Full freeze; a halted core stays halted underneath it.
         pc_we = 1'b0;
         fd_we = 1'b0;
         dx_we = 1'b0;
         xm_we = 1'b0;
         if (state_reg != HALT)
            state_next = MSTALL;
      end else if (state_reg == HALT) begin
         // Keep feeding bubbles so older instructions drain out.
         pc_we    = 1'b0;
         fd_flush = 1'b1;
         dx_flush = 1'b1;
      end else if (br_taken) begin
         // Redirect wins over hazards and fetch stalls; squash FD and DX.
         fd_flush = 1'b1;
         dx_flush = 1'b1;
      end else if (data_hazard) begin
         pc_we    = 1'b0;
         fd_we    = 1'b0;
         dx_flush = 1'b1;
      end else if (imem_stall) begin
         pc_we    = 1'b0;
         fd_flush = 1'b1;
         if (fd_valid && fd_halt)
            state_next = HALT;
      end else begin
         if (fd_valid && fd_halt)
            state_next = HALT;
      end

      if (rst) begin
         pc_we    = 1'b0;
         fd_we    = 1'b0;
         fd_flush = 1'b1;
         dx_we    = 1'b0;
         dx_flush = 1'b1;
         xm_we    = 1'b0;
      end
   end

   assign halted    = (state_reg == HALT) & ~rst;
   assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl in its default build (no forwarding).
// Control outputs are packed as {pc_we,fd_we,fd_flush,dx_we,dx_flush,xm_we,halted}.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        fd_valid, fd_uses_rs, fd_uses_rt, fd_halt;
   logic [2:0]  fd_rs, fd_rt, dx_rd, xm_rd;
   logic        dx_regwrite, dx_memread, xm_regwrite;
   logic        br_taken, imem_stall, dmem_stall;
   logic        pc_we, fd_we, fd_flush, dx_we, dx_flush, xm_we, halted;
   logic [15:0] stall_cnt;

   int total = 0;
   int bad   = 0;

   localparam logic [6:0] C_RESET  = 7'b0010100;
   localparam logic [6:0] C_FREEZE = 7'b0000000;
   localparam logic [6:0] C_HALTED = 7'b0111111;
   localparam logic [6:0] C_BRANCH = 7'b1111110;
   localparam logic [6:0] C_HAZ    = 7'b0001110;
   localparam logic [6:0] C_IMEM   = 7'b0111010;
   localparam logic [6:0] C_NORM   = 7'b1101010;

   pipe_hazard_ctrl #(.REG_W(3), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .fd_valid(fd_valid), .fd_rs(fd_rs), .fd_rt(fd_rt),
      .fd_uses_rs(fd_uses_rs), .fd_uses_rt(fd_uses_rt), .fd_halt(fd_halt),
      .dx_rd(dx_rd), .dx_regwrite(dx_regwrite), .dx_memread(dx_memread),
      .xm_rd(xm_rd), .xm_regwrite(xm_regwrite),
      .br_taken(br_taken), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
      .pc_we(pc_we), .fd_we(fd_we), .fd_flush(fd_flush),
      .dx_we(dx_we), .dx_flush(dx_flush), .xm_we(xm_we),
      .halted(halted), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ctl(input string tag, input logic [6:0] exp);
      logic [6:0] obs;
      #1;
      obs = {pc_we, fd_we, fd_flush, dx_we, dx_flush, xm_we, halted};
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s ctl observed=%b expected=%b", tag, obs, exp);
      end
      $display("check %s ctl=%b cnt=%0d", tag, obs, stall_cnt);
   endtask

   task automatic chk_cnt(input string tag, input logic [15:0] exp);
      total++;
      assert (stall_cnt === exp) else begin
         bad++;
         $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt, exp);
      end
   endtask

   task automatic clear_in();
      fd_valid = 0; fd_uses_rs = 0; fd_uses_rt = 0; fd_halt = 0;
      fd_rs = 0; fd_rt = 0; dx_rd = 0; xm_rd = 0;
      dx_regwrite = 0; dx_memread = 0; xm_regwrite = 0;
      br_taken = 0; imem_stall = 0; dmem_stall = 0;
   endtask

   initial begin
      rst = 1'b1;
      clear_in();
      #1;
      chk_ctl("reset_out", C_RESET);
      chk_cnt("reset_cnt", 16'd0);
      tick();
      rst = 1'b0;
      chk_ctl("idle", C_NORM);

      // Load-use on rs; without forwarding the producer also stalls from MEM.
      fd_valid = 1; fd_uses_rs = 1; fd_rs = 3'd1;
      dx_rd = 3'd1; dx_regwrite = 1; dx_memread = 1;
      chk_ctl("loaduse_ex", C_HAZ);
      tick();
      dx_regwrite = 0; dx_memread = 0; xm_rd = 3'd1; xm_regwrite = 1;
      chk_ctl("loaduse_mem", C_HAZ);
      tick();
      xm_regwrite = 0;
      chk_ctl("loaduse_done", C_NORM);
      chk_cnt("loaduse_cnt", 16'd2);

      // ALU producer on rt; use bit gates the compare.
      clear_in();
      fd_valid = 1; fd_uses_rt = 1; fd_rt = 3'd5; dx_rd = 3'd5; dx_regwrite = 1;
      chk_ctl("alu_rt", C_HAZ);
      tick();
      fd_uses_rt = 0;
      chk_ctl("rt_unused", C_NORM);
      fd_uses_rt = 1; fd_valid = 0;
      chk_ctl("fd_invalid", C_NORM);
      chk_cnt("alu_cnt", 16'd3);

      // Branch overrides load-use and imem stall.
      clear_in();
      fd_valid = 1; fd_uses_rs = 1; fd_rs = 3'd2; dx_rd = 3'd2;
      dx_regwrite = 1; dx_memread = 1; imem_stall = 1; br_taken = 1;
      chk_ctl("branch_override", C_BRANCH);
      tick();
      chk_cnt("branch_cnt", 16'd3);

      // Fetch stall alone.
      clear_in();
      imem_stall = 1;
      chk_ctl("imem", C_IMEM);
      tick();
      chk_cnt("imem_cnt", 16'd4);

      // Data-memory freeze for three cycles; a branch does not break it.
      clear_in();
      dmem_stall = 1;
      chk_ctl("dmem1", C_FREEZE);
      tick();
      br_taken = 1;
      chk_ctl("dmem2_br", C_FREEZE);
      tick();
      br_taken = 0;
      chk_ctl("dmem3", C_FREEZE);
      tick();
      dmem_stall = 0;
      chk_ctl("dmem_release", C_NORM);
      chk_cnt("dmem_cnt", 16'd7);

      // Asynchronous reset in the middle of a freeze.
      dmem_stall = 1;
      tick();
      rst = 1;
      chk_ctl("rst_mid_mstall", C_RESET);
      chk_cnt("rst_mid_cnt", 16'd0);
      tick();
      rst = 0; dmem_stall = 0;
      chk_ctl("post_rst", C_NORM);

      // HALT squashed by a branch does not halt.
      fd_valid = 1; fd_halt = 1; br_taken = 1;
      chk_ctl("halt_br", C_BRANCH);
      tick();
      clear_in();
      chk_ctl("halt_br_after", C_NORM);

      // HALT blocked by a hazard does not advance, so no halt.
      fd_valid = 1; fd_halt = 1; fd_uses_rs = 1; fd_rs = 3'd4;
      dx_rd = 3'd4; dx_regwrite = 1;
      chk_ctl("halt_haz", C_HAZ);
      tick();
      clear_in();
      chk_ctl("halt_haz_after", C_NORM);
      chk_cnt("halt_haz_cnt", 16'd1);

      // Clean HALT retires into the halted drain state.
      fd_valid = 1; fd_halt = 1;
      chk_ctl("halt_enter", C_NORM);
      tick();
      clear_in();
      chk_ctl("halted1", C_HALTED);
      tick();
      imem_stall = 1;
      chk_ctl("halted2_imem", C_HALTED);
      tick();
      chk_ctl("halted3", C_HALTED);
      chk_cnt("halted_cnt", 16'd1);

      // Only reset leaves HALT.
      rst = 1;
      chk_ctl("halt_rst", C_RESET);
      tick();
      rst = 0; clear_in();
      chk_ctl("halt_rst_after", C_NORM);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Drives the write-enable and flush (bubble) controls of PC, FD_pipe, DX_pipe and XM_pipe.
- Sources of stalls and flushes: RAW data hazards, load-use hazards, taken branches/jumps resolved in EX, instruction-memory and data-memory busy stalls, and HALT retirement.
- Sits beside decode; its outputs feed the pipe registers' write-enable and flush muxes. A flush replaces the stage payload with NOP (16'h0800) and all control bits with 0.

Parameters:
- REG_W, 3, register-specifier width.
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- fd_valid  in  1  FD holds a real instruction
- fd_rs  in  REG_W  decode source register 1
- fd_rt  in  REG_W  decode source register 2
- fd_uses_rs  in  1  decode instruction reads rs
- fd_uses_rt  in  1  decode instruction reads rt
- fd_halt  in  1  decode instruction is HALT
- dx_rd  in  REG_W  EX destination register
- dx_regwrite  in  1  EX instruction writes a register
- dx_memread  in  1  EX instruction is a load
- xm_rd  in  REG_W  MEM destination register
- xm_regwrite  in  1  MEM instruction writes a register
- br_taken  in  1  EX resolved a taken branch or jump this cycle
- imem_stall  in  1  instruction memory not ready
- dmem_stall  in  1  data memory not ready
- pc_we  out  1  PC register update
- fd_we  out  1  FD_pipe capture
- fd_flush  out  1  FD_pipe loads NOP
- dx_we  out  1  DX_pipe capture
- dx_flush  out  1  DX_pipe loads bubble
- xm_we  out  1  XM_pipe/MW_pipe capture
- halted  out  1  core halted
- stall_cnt  out  CNT_W  count of cycles with pc_we=0 while not halted

Behaviour:
- State register (asynchronous reset): RUN, MSTALL, HALT. Reset state is RUN; stall_cnt resets to 0.
- While rst is high, outputs are: pc_we=0, fd_we=0, fd_flush=1, dx_we=0, dx_flush=1, xm_we=0, halted=0.
- Hazard terms:
  - raw_dx = dx_regwrite & ((fd_uses_rs & fd_rs==dx_rd) | (fd_uses_rt & fd_rt==dx_rd)).
  - raw_xm is the same comparison against xm_rd/xm_regwrite.
  - Both terms are gated by fd_valid.
  - Register file writes through, so the MW stage never causes a hazard.
- Output priority, evaluated per cycle (first match wins):
  1. dmem_stall=1 or state MSTALL with dmem_stall=1 → all we=0 and all flush=0 (full freeze). Next state is MSTALL.
  2. state HALT → pc_we=0, fd_flush=1, fd_we=1, dx_flush=1, dx_we=1, xm_we=1, so older instructions drain.
  3. br_taken=1 → pc_we=1 (target), fd_flush=1, dx_flush=1, fd_we=dx_we=xm_we=1. This flush overrides any data hazard and any imem_stall.
  4. data hazard (see Optional Feature) → pc_we=0, fd_we=0, dx_flush=1, dx_we=1, xm_we=1.
  5. imem_stall=1 → pc_we=0, fd_flush=1, fd_we=1, dx_we=xm_we=1.
  6. Otherwise all we=1 and all flush=0.
- Leaving MSTALL: when dmem_stall falls, the FSM returns to RUN and the same cycle uses the normal priority. There is no lost or duplicated capture.
- HALT entry: fd_valid & fd_halt, taken under rule 6 or rule 5 (i.e. HALT advances into DX), moves the FSM to HALT at the next edge.
  - A HALT cancelled by br_taken does not halt.
  - halted=1 in HALT; only rst exits HALT.
- stall_cnt increments when pc_we=0 and state≠HALT and rst=0. It saturates at all-ones.

Optional Feature:
- Macro: PIPE_FORWARD_EN.
- Defined: the data hazard is raw_dx & dx_memread only (load-use, exactly 1 bubble); EX→EX and MEM→EX forwarding is assumed.
- Undefined: the data hazard is raw_dx | raw_xm. Stalls last until the producer leaves MEM (up to 2 bubbles).

Decomposition:
- Package pipe_ctrl_pkg: state enum (RUN/MSTALL/HALT), NOP_INSTR=16'h0800, REG_W default.
- One natural sub-module: hazard_cmp. It takes a source/dest pair plus use/write bits and returns a match; it is instantiated for the rs/rt × dx/xm comparisons.

Test Plan:
- Load r1 in EX (dx_memread=1, dx_rd=1), FD reads rs=1 → one cycle pc_we=0, fd_we=0, dx_flush=1, then normal; stall_cnt=1. Without PIPE_FORWARD_EN, an ALU producer also stalls 2 cycles.
- br_taken=1 coincident with a load-use hazard and imem_stall=1 → pc_we=1, fd_flush=1, dx_flush=1; no stall that cycle.
- dmem_stall high for 3 cycles → all we=0 for 3 cycles, state MSTALL; resumes RUN on drop; stall_cnt+=3.
- HALT in FD, no hazard → next edge halted=1, pc_we=0 forever, XM drains. HALT in FD with br_taken=1 → halted stays 0.
- imem_stall=1 with no hazard → pc_we=0, FD loads NOP, DX/XM advance.
- Assert rst mid-MSTALL → immediate RUN, stall_cnt=0, reset output values; after release, normal flow.
